lbp_window_sequencer: RTL and testbench
=======================================

Name: lbp_window_sequencer

Overview:
- Sequences the gray-image fetch and LBP write-back for the 3x3 sliding-window LBP datapath.
- Instead of re-reading all 9 neighbours per pixel, it shifts the window one column and fetches only the 3 new pixels of the incoming column.
- Drives the gray-memory request/address, window-register shift/load strobes, the LBP output-register enable and the lbp write handshake, then raises finish.
- Replaces the 9-fetch-per-pixel control flow. The window registers and the LBP compare logic stay in the datapath.

Parameters:
- IMG_W, 128, image width in pixels (>=3).
- IMG_H, 128, image height in pixels (>=3).
- AW, 14, address width; IMG_W*IMG_H <= 2**AW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- gray_ready  in  1  image available; sampled only in IDLE.
- gray_req  out  1  gray memory read request; data returns the next cycle.
- gray_addr  out  AW  gray read address.
- win_shift  out  1  shift the 3x3 window left one column.
- win_load  out  3  one-hot; load returned gray_data into the right-column row k (bit0 = top).
- lbp_en  out  1  datapath latches the LBP result of the current window.
- lbp_addr  out  AW  write address of the centre pixel.
- lbp_valid  out  1  lbp_data/lbp_addr valid; single-cycle write strobe.
- finish  out  1  whole image processed.

Behaviour:
- Moore outputs only: every output is decoded from registered state/counters. There is no combinational path from gray_ready to any output.
- Counters:
  - r = centre row, 1..IMG_H-2.
  - c = fetched column, 0..IMG_W-1.
  - k = fetch row offset, 0..2.
- States: IDLE, F0, F1, F2, LD, CALC, WR, DONE.
- Reset (async, any state, mid-operation included): state=IDLE, r=1, c=0, k=0. All outputs 0, both address outputs included. A later gray_ready restarts from pixel 0.
- IDLE:
  - Outputs 0.
  - gray_ready=1 at a clock edge → F0 on the next cycle; otherwise stay.
  - gray_ready is ignored in all other states.
- Fx (x=0,1,2):
  - gray_req=1, gray_addr=(r-1+x)*IMG_W+c.
  - F0 also asserts win_shift=1.
  - F1 asserts win_load[0]; F2 asserts win_load[1].
  - Load strobes trail their request by one cycle.
- LD:
  - win_load[2]=1, gray_req=0.
  - If c>=2 → CALC.
  - Else c increments → F0.
- CALC: lbp_en=1; the window centre is column c-1 → WR.
- WR:
  - lbp_valid=1 for exactly one cycle, lbp_addr=r*IMG_W+(c-1).
  - If c<IMG_W-1: c++ → F0.
  - Else if r<IMG_H-2: c=0, r++ → F0.
  - Else → DONE.
- DONE: finish=1 and held; all other outputs 0; only reset leaves DONE.
- At every row start columns 0,1,2 are fetched with shifts, so stale window contents are flushed. No CALC/WR occurs for c<2.
- Border pixels (row 0, row IMG_H-1, column 0, column IMG_W-1) are never written; the memory default of 0 stands.
- Outputs when inactive:
  - gray_addr is meaningful only while gray_req=1; otherwise it holds its last value.
  - lbp_addr holds its last value outside WR.
- Latency:
  - Per row: 4*IMG_W + 2*(IMG_W-2) = 6*IMG_W-4 cycles.
  - Image: (IMG_H-2)*(6*IMG_W-4) cycles from the first F0 to the first DONE cycle. Default: 96264.
- Mutual exclusion:
  - gray_req, lbp_en and lbp_valid are never high together.
  - win_shift never coincides with any win_load bit.
- Width: address arithmetic is in AW bits and does not overflow under the parameter constraint.

Test Plan:
- Reset values: assert reset low mid-cycle with gray_ready=1 → all outputs 0 immediately. After release with gray_ready=0 for 10 cycles → no gray_req.
- First-pixel sequence (default params): raise gray_ready → gray_addr sequence 0,128,256,1,129,257,2,130,258 on gray_req cycles.
  - win_shift on each F0; win_load 001/010/100 one cycle after each request.
  - Then lbp_en, then lbp_valid with lbp_addr=129.
- Row wrap: the first WR after lbp_addr=254 (r=1, c=127) → next gray_addr sequence 128,256,384 (row r=2, c=0). The next lbp_addr is 257.
- Full image, IMG_W=IMG_H=4 against a behavioural window model:
  - lbp_addr sequence 5,6,9,10.
  - finish rises exactly 40 cycles after the first F0.
  - No lbp_valid on border addresses; finish then stays high.
- Default full image: exactly 126*126=15876 lbp_valid pulses; last lbp_addr=16254; finish after 96264 cycles.
- Reset mid-operation: pulse reset during F1 of row 40 → outputs clear asynchronously. On gray_ready the sequence restarts at gray_addr 0, and the lbp_valid count restarts from 0.

Source files
------------

// File: rtl/lbp_window_sequencer.sv
// Fetch/write-back sequencer for the 3x3 LBP window: each step shifts the window one column
// and fetches only the three pixels of the incoming column, then strobes the LBP result out.
module lbp_window_sequencer #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  output logic          win_shift,
  output logic [2:0]    win_load,
  output logic          lbp_en,
  output logic [AW-1:0] lbp_addr,
  output logic          lbp_valid,
  output logic          finish
);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, LD, CALC, WR, DONE} state_t;

  localparam logic [AW-1:0] W_A    = AW'(IMG_W);
  localparam logic [AW-1:0] C_LAST = AW'(IMG_W - 1);
  localparam logic [AW-1:0] R_LAST = AW'(IMG_H - 2);
  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [AW-1:0] TWO    = AW'(2);

  state_t        state, state_d;
  logic [AW-1:0] r, r_d;
  logic [AW-1:0] c, c_d;
  logic [1:0]    k, k_d;
  logic [AW-1:0] gray_addr_d, lbp_addr_d;

  always_comb begin
    state_d = state;
    r_d     = r;
    c_d     = c;
    k_d     = k;
    case (state)
      IDLE: if (gray_ready) begin
        state_d = F0;
        r_d     = ONE;
        c_d     = '0;
        k_d     = '0;
      end
      F0: begin
        state_d = F1;
        k_d     = 2'd1;
      end
      F1: begin
        state_d = F2;
        k_d     = 2'd2;
      end
      F2: begin
        state_d = LD;
        k_d     = 2'd0;
      end
      LD: if (c >= TWO) begin
        state_d = CALC;
      end else begin
        state_d = F0;
        c_d     = c + ONE;
      end
      CALC: state_d = WR;
      WR: if (c < C_LAST) begin
        state_d = F0;
        c_d     = c + ONE;
      end else if (r < R_LAST) begin
        state_d = F0;
        c_d     = '0;
        r_d     = r + ONE;
      end else begin
        state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are computed from the next-state counters and registered, so they are
  // valid in the very cycle the request/strobe is decoded and hold their value otherwise.
  assign gray_addr_d = (r_d - ONE + AW'(k_d)) * W_A + c_d;
  assign lbp_addr_d  = r_d * W_A + c_d - ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      r         <= ONE;
      c         <= '0;
      k         <= '0;
      gray_addr <= '0;
      lbp_addr  <= '0;
    end else begin
      state <= state_d;
      r     <= r_d;
      c     <= c_d;
      k     <= k_d;
      if (state_d inside {F0, F1, F2}) gray_addr <= gray_addr_d;
      if (state_d == WR) lbp_addr <= lbp_addr_d;
    end
  end

  always_comb begin
    gray_req  = 1'b0;
    win_shift = 1'b0;
    win_load  = 3'b000;
    lbp_en    = 1'b0;
    lbp_valid = 1'b0;
    finish    = 1'b0;
    case (state)
      F0: begin
        gray_req  = 1'b1;
        win_shift = 1'b1;
      end
      F1: begin
        gray_req = 1'b1;
        win_load = 3'b001;
      end
      F2: begin
        gray_req = 1'b1;
        win_load = 3'b010;
      end
      LD:      win_load  = 3'b100;
      CALC:    lbp_en    = 1'b1;
      WR:      lbp_valid = 1'b1;
      DONE:    finish    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lbp_window_sequencer.sv
// Scoreboard bench for lbp_window_sequencer: default-size, 4x4 and 6x5 instances.
`timescale 1ns/1ps
module tb_lbp_window_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int gq[$];
  int lq[$];
  int cq[$];
  int lbp_cnt;

  // default-size instance
  logic        rst_a, rdy_a, req_a, shift_a, en_a, valid_a, fin_a;
  logic [13:0] gaddr_a, laddr_a;
  logic [2:0]  load_a;
  // 4x4 instance
  logic        rst_b, rdy_b, req_b, shift_b, en_b, valid_b, fin_b;
  logic [3:0]  gaddr_b, laddr_b;
  logic [2:0]  load_b;
  // 6x5 instance
  logic        rst_c, rdy_c, req_c, shift_c, en_c, valid_c, fin_c;
  logic [4:0]  gaddr_c, laddr_c;
  logic [2:0]  load_c;

  lbp_window_sequencer u_def (
    .clk(clk), .reset(rst_a), .gray_ready(rdy_a), .gray_req(req_a), .gray_addr(gaddr_a),
    .win_shift(shift_a), .win_load(load_a), .lbp_en(en_a), .lbp_addr(laddr_a),
    .lbp_valid(valid_a), .finish(fin_a));

  lbp_window_sequencer #(.IMG_W(4), .IMG_H(4), .AW(4)) u_s4 (
    .clk(clk), .reset(rst_b), .gray_ready(rdy_b), .gray_req(req_b), .gray_addr(gaddr_b),
    .win_shift(shift_b), .win_load(load_b), .lbp_en(en_b), .lbp_addr(laddr_b),
    .lbp_valid(valid_b), .finish(fin_b));

  lbp_window_sequencer #(.IMG_W(6), .IMG_H(5), .AW(5)) u_s6 (
    .clk(clk), .reset(rst_c), .gray_ready(rdy_c), .gray_req(req_c), .gray_addr(gaddr_c),
    .win_shift(shift_c), .win_load(load_c), .lbp_en(en_c), .lbp_addr(laddr_c),
    .lbp_valid(valid_c), .finish(fin_c));

  task automatic test_reset();
    @(negedge clk);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    for (int i = 0; i < 20 && !(req_a && gaddr_a != 0); i++) @(negedge clk);
    n_vec++;
    if (!(req_a && gaddr_a != 0)) begin
      n_err++;
      $display("FAIL reset_setup: req=%0b addr=%0d, required active request", req_a, gaddr_a);
    end
    #2 rst_a = 1'b0;
    rdy_a = 1'b1;
    #1;
    n_vec++;
    if ({req_a, gaddr_a, shift_a, load_a, en_a, laddr_a, valid_a, fin_a} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%0b gaddr=%0d shift=%0b load=%b en=%0b laddr=%0d valid=%0b fin=%0b, required all 0",
               req_a, gaddr_a, shift_a, load_a, en_a, laddr_a, valid_a, fin_a);
    end
    repeat (3) @(negedge clk);
    rdy_a = 1'b0;
    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (req_a !== 1'b0) begin
        n_err++;
        $display("FAIL idle_no_req: cycle %0d gray_req=%0b, required 0", i, req_a);
      end
    end
  endtask

  task automatic test_first_pixel();
    logic       prev_req, prev_en;
    logic [2:0] exp_load;
    int         kk, prev_k;
    gq = '{0, 128, 256, 1, 129, 257, 2, 130, 258};
    lq = '{129};
    prev_req = 1'b0; prev_en = 1'b0; kk = 0; prev_k = 0;
    lbp_cnt = 0;
    rdy_a = 1'b1;
    for (int i = 0; i < 60 && lq.size() != 0; i++) begin
      @(negedge clk);
      if (i == 0) rdy_a = 1'b0;
      exp_load = prev_req ? (3'b001 << prev_k) : 3'b000;
      n_vec++;
      if (load_a !== exp_load) begin
        n_err++;
        $display("FAIL first_win_load: cycle %0d load=%b, required %b", i, load_a, exp_load);
      end
      n_vec++;
      if (shift_a !== (req_a && kk == 0)) begin
        n_err++;
        $display("FAIL first_win_shift: cycle %0d shift=%0b, required %0b", i, shift_a, req_a && kk == 0);
      end
      n_vec++;
      if (int'(req_a) + int'(en_a) + int'(valid_a) > 1) begin
        n_err++;
        $display("FAIL first_mutex: req=%0b en=%0b valid=%0b, required at most one", req_a, en_a, valid_a);
      end
      if (req_a) begin
        n_vec++;
        if (gq.size() == 0) begin
          n_err++;
          $display("FAIL first_extra_req: addr=%0d, required no request", gaddr_a);
        end else if (int'(gaddr_a) != gq[0]) begin
          n_err++;
          $display("FAIL first_gray_addr: got %0d, required %0d", gaddr_a, gq[0]);
        end
        if (gq.size() != 0) void'(gq.pop_front());
        prev_k = kk;
        kk = (kk + 1) % 3;
      end
      if (valid_a) begin
        lbp_cnt++;
        n_vec++;
        if (int'(laddr_a) != lq[0] || !prev_en) begin
          n_err++;
          $display("FAIL first_lbp: addr=%0d prev_en=%0b, required addr %0d after lbp_en", laddr_a, prev_en, lq[0]);
        end
        void'(lq.pop_front());
      end
      prev_req = req_a;
      prev_en  = en_a;
    end
    n_vec++;
    if (lq.size() != 0 || gq.size() != 0) begin
      n_err++;
      $display("FAIL first_timeout: %0d lbp / %0d gray expectations left, required 0", lq.size(), gq.size());
    end
  endtask

  task automatic test_row_wrap();
    logic prev_valid;
    gq.delete();
    lq.delete();
    for (int c = 3; c < 128; c++)
      for (int k = 0; k < 3; k++) gq.push_back(k * 128 + c);
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 3; k++) gq.push_back((1 + k) * 128 + c);
    for (int c = 2; c < 127; c++) lq.push_back(128 + c);
    lq.push_back(257);
    prev_valid = 1'b0;
    for (int i = 0; i < 2000 && lq.size() != 0; i++) begin
      @(negedge clk);
      if (req_a) begin
        n_vec++;
        if (gq.size() == 0) begin
          n_err++;
          $display("FAIL wrap_extra_req: addr=%0d, required no request", gaddr_a);
        end else begin
          if (int'(gaddr_a) != gq[0]) begin
            n_err++;
            $display("FAIL wrap_gray_addr: got %0d, required %0d", gaddr_a, gq[0]);
          end
          void'(gq.pop_front());
        end
      end
      if (valid_a) begin
        lbp_cnt++;
        n_vec++;
        if (int'(laddr_a) != lq[0] || prev_valid) begin
          n_err++;
          $display("FAIL wrap_lbp: addr=%0d prev_valid=%0b, required addr %0d single pulse", laddr_a, prev_valid, lq[0]);
        end
        void'(lq.pop_front());
      end
      prev_valid = valid_a;
    end
    n_vec++;
    if (lq.size() != 0 || gq.size() != 0) begin
      n_err++;
      $display("FAIL wrap_timeout: %0d lbp / %0d gray expectations left, required 0", lq.size(), gq.size());
    end
  endtask

  task automatic test_reset_midop();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      @(negedge clk);
      if (valid_a) lbp_cnt++;
      if (load_a == 3'b001 && gaddr_a >= 14'd5120 && gaddr_a < 14'd5248) found = 1'b1;
    end
    n_vec++;
    if (!found || lbp_cnt != 39 * 126) begin
      n_err++;
      $display("FAIL midop_row40: found=%0b lbp count=%0d, required found with %0d", found, lbp_cnt, 39 * 126);
    end
    #2 rst_a = 1'b0;
    #1;
    n_vec++;
    if ({req_a, gaddr_a, shift_a, load_a, en_a, laddr_a, valid_a, fin_a} !== 36'd0) begin
      n_err++;
      $display("FAIL midop_clear: req=%0b gaddr=%0d load=%b laddr=%0d, required all 0", req_a, gaddr_a, load_a, laddr_a);
    end
    @(negedge clk);
    rst_a = 1'b1;
    lbp_cnt = 0;
    gq = '{0, 128, 256, 1};
    lq = '{129};
    @(negedge clk);
    rdy_a = 1'b1;
    for (int i = 0; i < 60 && lq.size() != 0; i++) begin
      @(negedge clk);
      if (i == 0) rdy_a = 1'b0;
      if (req_a && gq.size() != 0) begin
        n_vec++;
        if (int'(gaddr_a) != gq[0]) begin
          n_err++;
          $display("FAIL restart_gray_addr: got %0d, required %0d", gaddr_a, gq[0]);
        end
        void'(gq.pop_front());
      end
      if (valid_a) begin
        lbp_cnt++;
        n_vec++;
        if (int'(laddr_a) != lq[0]) begin
          n_err++;
          $display("FAIL restart_lbp_addr: got %0d, required %0d", laddr_a, lq[0]);
        end
        void'(lq.pop_front());
      end
    end
    n_vec++;
    if (lbp_cnt != 1 || lq.size() != 0 || gq.size() != 0) begin
      n_err++;
      $display("FAIL restart_count: lbp count=%0d left=%0d/%0d, required 1 and 0/0", lbp_cnt, lq.size(), gq.size());
    end
  endtask

  task automatic test_window_4x4();
    int   win[3][3];
    int   pend, cyc, bad, ctr, hold, a;
    logic started, seen_fin;
    gq.delete(); lq.delete(); cq.delete();
    for (int r = 1; r < 3; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 3; k++) gq.push_back((r - 1 + k) * 4 + c);
    lq = '{5, 6, 9, 10};
    cq = '{5, 6, 9, 10};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) win[i][j] = -1;
    pend = -1; cyc = 0; hold = 0; started = 1'b0; seen_fin = 1'b0;
    rdy_b = 1'b1;
    for (int i = 0; i < 200 && hold < 5; i++) begin
      @(negedge clk);
      if (i == 0) rdy_b = 1'b0;
      if (started) cyc++;
      for (int k = 0; k < 3; k++)
        if (load_b[k]) win[k][2] = pend;
      if (shift_b)
        for (int k = 0; k < 3; k++) begin
          win[k][0] = win[k][1];
          win[k][1] = win[k][2];
        end
      pend = -1;
      if (req_b) begin
        if (!started) begin
          started = 1'b1;
          cyc = 0;
        end
        n_vec++;
        if (gq.size() == 0 || int'(gaddr_b) != gq[0]) begin
          n_err++;
          $display("FAIL w4_gray_addr: got %0d, required %0d", gaddr_b, gq.size() ? gq[0] : -1);
        end
        if (gq.size() != 0) void'(gq.pop_front());
        pend = int'(gaddr_b);
      end
      if (en_b) begin
        ctr = (cq.size() != 0) ? cq.pop_front() : -100;
        bad = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            if (win[r][c] != ctr + (r - 1) * 4 + (c - 1)) bad++;
        n_vec++;
        if (bad != 0) begin
          n_err++;
          $display("FAIL w4_window: centre %0d has %0d wrong taps (top row %0d %0d %0d), required 0",
                   ctr, bad, win[0][0], win[0][1], win[0][2]);
        end
      end
      if (valid_b) begin
        a = int'(laddr_b);
        n_vec++;
        if (lq.size() == 0 || a != lq[0] || a % 4 == 0 || a % 4 == 3 || a < 4 || a >= 12) begin
          n_err++;
          $display("FAIL w4_lbp_addr: got %0d, required %0d (interior)", a, lq.size() ? lq[0] : -1);
        end
        if (lq.size() != 0) void'(lq.pop_front());
      end
      if (fin_b && !seen_fin) begin
        seen_fin = 1'b1;
        n_vec++;
        if (cyc != 40) begin
          n_err++;
          $display("FAIL w4_finish_latency: %0d cycles, required 40", cyc);
        end
      end else if (seen_fin) begin
        hold++;
        n_vec++;
        if (!fin_b || req_b || en_b || valid_b || shift_b || load_b != 3'b000) begin
          n_err++;
          $display("FAIL w4_done_hold: fin=%0b req=%0b valid=%0b, required fin only", fin_b, req_b, valid_b);
        end
      end
    end
    n_vec++;
    if (!seen_fin || gq.size() != 0 || lq.size() != 0) begin
      n_err++;
      $display("FAIL w4_timeout: finish=%0b left=%0d/%0d, required 1 and 0/0", seen_fin, gq.size(), lq.size());
    end
  endtask

  task automatic test_full_small();
    int   cyc, nreq, nlbp;
    logic started, seen_fin;
    lq.delete();
    for (int r = 1; r < 4; r++)
      for (int c = 1; c < 5; c++) lq.push_back(r * 6 + c);
    cyc = 0; nreq = 0; nlbp = 0; started = 1'b0; seen_fin = 1'b0;
    rdy_c = 1'b1;
    for (int i = 0; i < 300 && !seen_fin; i++) begin
      @(negedge clk);
      if (i == 0) rdy_c = 1'b0;
      if (started) cyc++;
      if (req_c) begin
        if (!started) begin
          started = 1'b1;
          cyc = 0;
        end
        nreq++;
      end
      if (valid_c) begin
        nlbp++;
        n_vec++;
        if (lq.size() == 0 || int'(laddr_c) != lq[0]) begin
          n_err++;
          $display("FAIL s6_lbp_addr: got %0d, required %0d", laddr_c, lq.size() ? lq[0] : -1);
        end
        if (lq.size() != 0) void'(lq.pop_front());
      end
      if (fin_c) seen_fin = 1'b1;
    end
    n_vec++;
    if (!seen_fin || cyc != 96 || nreq != 54 || nlbp != 12) begin
      n_err++;
      $display("FAIL s6_totals: finish=%0b cycles=%0d req=%0d lbp=%0d, required 1/96/54/12", seen_fin, cyc, nreq, nlbp);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (!fin_c || laddr_c != 5'd22 || gaddr_c != 5'd29 || req_c || valid_c) begin
      n_err++;
      $display("FAIL s6_done_hold: fin=%0b laddr=%0d gaddr=%0d, required 1/22/29", fin_c, laddr_c, gaddr_c);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    lbp_cnt = 0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    test_reset();
    test_first_pixel();
    test_row_wrap();
    test_reset_midop();
    test_window_4x4();
    test_full_small();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
